// File: rtl/c499_sec_pkg.sv
// Shared constants, codeword layout and the masked-XOR reference form of the
// c499 SEC check-bit equations.
package c499_sec_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;
  localparam int CW_W   = DATA_W + CHK_W;

  // Check bit j is the parity of the data bits selected by mask Mj.
  localparam logic [DATA_W-1:0] M0 = 32'h00FF1111;
  localparam logic [DATA_W-1:0] M1 = 32'hFF002222;
  localparam logic [DATA_W-1:0] M2 = 32'h0F0F4444;
  localparam logic [DATA_W-1:0] M3 = 32'hF0F08888;
  localparam logic [DATA_W-1:0] M4 = 32'h111100FF;
  localparam logic [DATA_W-1:0] M5 = 32'h2222FF00;
  localparam logic [DATA_W-1:0] M6 = 32'h44440F0F;
  localparam logic [DATA_W-1:0] M7 = 32'h8888F0F0;

  localparam logic [CHK_W-1:0][DATA_W-1:0] SEC_MASKS = {M7, M6, M5, M4, M3, M2, M1, M0};

  // Codeword bit numbering: 0..31 data, 32..39 check.
  typedef struct packed {
    logic [CHK_W-1:0]  check;
    logic [DATA_W-1:0] data;
  } codeword_t;

  // Reference check-bit computation (masked XOR form).
  function automatic logic [CHK_W-1:0] sec_check(input logic [DATA_W-1:0] data);
    logic [CHK_W-1:0] chk;
    chk = '0;
    for (int j = 0; j < CHK_W; j++) begin
      chk[j] = ^(data & SEC_MASKS[j]);
    end
    return chk;
  endfunction

endpackage

// File: rtl/c499_sec_encoder.sv
// Two-stage pipelined c499 SEC check-bit generator with valid/ready streams
// and optional single-bit error injection on the emitted codeword.
// Stage 1 folds the data word into nibble and column parities; stage 2
// combines them into the 8 check bits, applies injection and registers the
// codeword.
module c499_sec_encoder
  import c499_sec_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic              inj_en,
  input  logic [5:0]        inj_pos,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CHK_W-1:0]  out_check,
  output logic              out_injected
);

  // Stage 1 state
  logic              s1_valid;
  logic [DATA_W-1:0] s1_data;
  logic              s1_inj_en;
  logic [5:0]        s1_inj_pos;
  logic [7:0]        s1_p;
  logic [7:0]        s1_q;

  // Combinational partial parities of the incoming word
  logic [7:0] p_in;
  logic [7:0] q_in;

  // Stage 2 combinational results
  logic [CHK_W-1:0] chk;
  logic [CW_W-1:0]  flip;
  codeword_t        cw_next;

  logic s2_adv;

  // Stage 2 can take a new word whenever its output slot is empty or draining;
  // stage 1 can take one when it is empty or handing its word to stage 2.
  assign s2_adv   = !out_valid || out_ready;
  assign in_ready = !s1_valid || s2_adv;

  // Nibble parities p[n] and column parities q[i] of the incoming word.
  // NOTE: every always_comb output gets a default before any loop or branch so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    p_in = '0;
    q_in = '0;
    for (int n = 0; n < 8; n++) begin
      p_in[n] = ^in_data[4*n +: 4];
    end
    for (int i = 0; i < 4; i++) begin
      q_in[i]     = in_data[i]      ^ in_data[i+4]  ^ in_data[i+8]  ^ in_data[i+12];
      q_in[4 + i] = in_data[16 + i] ^ in_data[20+i] ^ in_data[24+i] ^ in_data[28+i];
    end
  end

  // Stage 1 register: accept a word, or drain to stage 2 and go empty.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid   <= 1'b0;
      s1_data    <= '0;
      s1_inj_en  <= 1'b0;
      s1_inj_pos <= '0;
      s1_p       <= '0;
      s1_q       <= '0;
    end else if (in_ready) begin
      s1_valid <= in_valid;
      if (in_valid) begin
        s1_data    <= in_data;
        s1_inj_en  <= inj_en;
        s1_inj_pos <= inj_pos;
        s1_p       <= p_in;
        s1_q       <= q_in;
      end
    end
  end

  // Combine partial parities into check bits and build the injection mask.
  always_comb begin
    chk[0] = s1_p[4] ^ s1_p[5] ^ s1_q[0];
    chk[1] = s1_p[6] ^ s1_p[7] ^ s1_q[1];
    chk[2] = s1_p[4] ^ s1_p[6] ^ s1_q[2];
    chk[3] = s1_p[5] ^ s1_p[7] ^ s1_q[3];
    chk[4] = s1_p[0] ^ s1_p[1] ^ s1_q[4];
    chk[5] = s1_p[2] ^ s1_p[3] ^ s1_q[5];
    chk[6] = s1_p[0] ^ s1_p[2] ^ s1_q[6];
    chk[7] = s1_p[1] ^ s1_p[3] ^ s1_q[7];
    flip = '0;
    if (s1_inj_en && (s1_inj_pos < 6'd40)) begin
      flip = CW_W'(1) << s1_inj_pos;
    end
    cw_next = codeword_t'({chk, s1_data} ^ flip);
  end

  // Stage 2 output register: holds while stalled, otherwise takes stage 1.
  // The data path is cleared by reset so a flushed pipeline shows zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid    <= 1'b0;
      out_data     <= '0;
      out_check    <= '0;
      out_injected <= 1'b0;
    end else if (s2_adv) begin
      out_valid <= s1_valid;
      if (s1_valid) begin
        out_data     <= cw_next.data;
        out_check    <= cw_next.check;
        out_injected <= |flip;
      end
    end
  end

endmodule

// File: tb/tb_c499_sec_encoder.sv
// Self-checking bench for c499_sec_encoder: directed vector table, a random
// stalled stream scored against the package reference, and hand-written
// stall/release and mid-stream reset sequences.
module tb_c499_sec_encoder;
  import c499_sec_pkg::*;

  logic              clk;
  logic              rst;
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_data;
  logic              inj_en;
  logic [5:0]        inj_pos;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [CHK_W-1:0]  out_check;
  logic              out_injected;

  int n_checks = 0;
  int n_errors = 0;

  c499_sec_encoder dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .inj_en       (inj_en),
    .inj_pos      (inj_pos),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_check    (out_check),
    .out_injected (out_injected)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [31:0] data;
    logic        en;
    logic [5:0]  pos;
    logic [31:0] exp_data;
    logic [7:0]  exp_check;
    logic        exp_inj;
  } vec_t;

  vec_t vecs[11];

  logic [31:0] exp_q[$];
  logic [31:0] exp_word;
  logic [41:0] snap;
  logic [31:0] seq_words[5];

  initial begin
    int sent, received, cycles, seen;
    bit hold;

    vecs[0]  = '{32'h00000000, 1'b0, 6'd0,  32'h00000000, 8'h00, 1'b0};
    vecs[1]  = '{32'h00000001, 1'b0, 6'd0,  32'h00000001, 8'h51, 1'b0};
    vecs[2]  = '{32'h80000000, 1'b0, 6'd0,  32'h80000000, 8'h8A, 1'b0};
    vecs[3]  = '{32'hFFFFFFFF, 1'b0, 6'd0,  32'hFFFFFFFF, 8'h00, 1'b0};
    vecs[4]  = '{32'h00010000, 1'b0, 6'd0,  32'h00010000, 8'h15, 1'b0};
    vecs[5]  = '{32'h00000001, 1'b1, 6'd5,  32'h00000021, 8'h51, 1'b1};
    vecs[6]  = '{32'h00000001, 1'b1, 6'd39, 32'h00000001, 8'hD1, 1'b1};
    vecs[7]  = '{32'h00000001, 1'b1, 6'd45, 32'h00000001, 8'h51, 1'b0};
    vecs[8]  = '{32'h00000001, 1'b1, 6'd40, 32'h00000001, 8'h51, 1'b0};
    vecs[9]  = '{32'h80000000, 1'b1, 6'd32, 32'h80000000, 8'h8B, 1'b1};
    vecs[10] = '{32'h00000001, 1'b0, 6'd5,  32'h00000001, 8'h51, 1'b0};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; inj_en = 1'b0; inj_pos = '0; out_ready = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("reset_state", {in_ready, out_valid, out_injected, out_data, out_check},
          {1'b1, 1'b0, 1'b0, 32'h0, 8'h0});

    // Directed vectors: one word at a time, exact two-edge latency.
    for (int v = 0; v < 11; v++) begin
      in_valid = 1'b1; in_data = vecs[v].data; inj_en = vecs[v].en; inj_pos = vecs[v].pos;
      step();
      in_valid = 1'b0; in_data = $urandom; inj_en = 1'b1; inj_pos = 6'd3;
      check($sformatf("vec%0d_not_early", v), out_valid, 1'b0);
      step();
      check($sformatf("vec%0d", v), {out_valid, out_injected, out_data, out_check},
            {1'b1, vecs[v].exp_inj, vecs[v].exp_data, vecs[v].exp_check});
      step();
    end
    inj_en = 1'b0;

    // Random stream with random backpressure, scored against sec_check.
    sent = 0; received = 0; cycles = 0; hold = 0; snap = '0;
    while (received < 10000 && cycles < 60000) begin
      in_valid  = (sent < 10000) && ($urandom_range(0, 9) < 7);
      in_data   = $urandom;
      out_ready = $urandom_range(0, 1) == 1;
      #4;
      if (hold) begin
        check("stall_stable", {out_valid, out_injected, out_data, out_check}, snap);
      end
      hold = out_valid && !out_ready;
      snap = {out_valid, out_injected, out_data, out_check};
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("stream_extra_word", {out_data, out_check}, 64'hx);
        end else begin
          exp_word = exp_q.pop_front();
          check("stream_word", {out_injected, out_data, out_check},
                {1'b0, exp_word, sec_check(exp_word)});
        end
        received++;
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(in_data);
        sent++;
      end
      step();
      cycles++;
    end
    check("stream_complete", received, 10000);
    check("stream_queue_empty", exp_q.size(), 0);
    in_valid = 1'b0;
    out_ready = 1'b1;
    step(); step();

    // Stall/release: fill both stages, hold 5 cycles, then stream with no bubble.
    seq_words[0] = 32'h0000000A; seq_words[1] = 32'h000000B0; seq_words[2] = 32'h00000C00;
    seq_words[3] = 32'h0000D000; seq_words[4] = 32'h000E0000;
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = seq_words[0]; step();
    in_data = seq_words[1]; step();
    in_data = seq_words[2];
    for (int c = 0; c < 5; c++) begin
      #4;
      check($sformatf("stall%0d", c), {in_ready, out_valid, out_data}, {1'b0, 1'b1, seq_words[0]});
      step();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      in_valid = (c < 3);
      in_data  = (c < 3) ? seq_words[c + 2] : 32'hDEADBEEF;
      #4;
      if (c < 3) check($sformatf("release_ready%0d", c), in_ready, 1'b1);
      check($sformatf("release_out%0d", c), {out_valid, out_data, out_check},
            {1'b1, seq_words[c], sec_check(seq_words[c])});
      step();
    end
    in_valid = 1'b0;
    step();
    check("drained", out_valid, 1'b0);

    // Reset with both stages full discards everything.
    out_ready = 1'b0;
    in_valid = 1'b1; in_data = 32'h12345678; step();
    in_data = 32'h9ABCDEF0; step();
    in_valid = 1'b0;
    check("full_before_reset", {out_valid, in_ready}, {1'b1, 1'b0});
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("flush_reset", {out_valid, out_injected, out_data, out_check, in_ready},
          {1'b0, 1'b0, 32'h0, 8'h0, 1'b1});
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      #4;
      if (out_valid) seen++;
      step();
    end
    check("flushed_words_gone", seen, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
